// File: rtl/c1908_secded.sv
// Registered 16-bit SEC/DED decoder (c1908 function): corrected data, syndrome and error class.
// Optional input register stage: define C1908_SECDED_INREG_EN for 2-cycle latency.
module c1908_secded #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CHK_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              correct_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  check_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CHK_W-1:0]  syndrome_out,
  output logic              single_err,
  output logic              double_err,
  output logic              out_valid
);

  localparam int unsigned HAM_W   = CHK_W - 1;
  localparam int unsigned MAX_POS = DATA_W + HAM_W;

  // Codeword position of data bit idx: non-powers-of-two 3,5,6,7,9..15,17..21.
  function automatic logic [HAM_W-1:0] data_pos(input int unsigned idx);
    logic [HAM_W-1:0] pos;
    if (idx == 0)       pos = HAM_W'(3);
    else if (idx < 4)   pos = HAM_W'(idx + 4);
    else if (idx < 11)  pos = HAM_W'(idx + 5);
    else                pos = HAM_W'(idx + 6);
    return pos;
  endfunction

  logic              stg_valid;
  logic              stg_correct;
  logic [DATA_W-1:0] stg_data;
  logic [CHK_W-1:0]  stg_check;

`ifdef C1908_SECDED_INREG_EN
  // Input stage: captured every cycle; validity travels with stg_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid   <= 1'b0;
      stg_correct <= 1'b0;
      stg_data    <= '0;
      stg_check   <= '0;
    end else begin
      stg_valid   <= in_valid;
      stg_correct <= correct_en;
      stg_data    <= data_in;
      stg_check   <= check_in;
    end
  end
`else
  assign stg_valid   = in_valid;
  assign stg_correct = correct_en;
  assign stg_data    = data_in;
  assign stg_check   = check_in;
`endif

  logic [HAM_W-1:0]  exp_chk;
  logic [HAM_W-1:0]  syn_ham;
  logic              syn_par;
  logic              single_c;
  logic              double_c;
  logic [DATA_W-1:0] fixed_c;

  // Syndrome, classification and optional single-bit repair.
  always_comb begin
    exp_chk = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      exp_chk = exp_chk ^ ({HAM_W{stg_data[i]}} & data_pos(i));
    end
    syn_ham  = exp_chk ^ stg_check[HAM_W-1:0];
    syn_par  = ^{stg_data, stg_check};
    single_c = syn_par & (32'(syn_ham) <= MAX_POS);
    double_c = syn_par ? (32'(syn_ham) > MAX_POS) : (syn_ham != '0);
    fixed_c  = stg_data;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (stg_correct && single_c && (data_pos(i) == syn_ham)) begin
        fixed_c[i] = ~stg_data[i];
      end
    end
  end

  // Output stage: holds its contents on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out     <= '0;
      syndrome_out <= '0;
      single_err   <= 1'b0;
      double_err   <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= stg_valid;
      if (stg_valid) begin
        data_out     <= fixed_c;
        syndrome_out <= {syn_par, syn_ham};
        single_err   <= single_c;
        double_err   <= double_c;
      end
    end
  end

endmodule

// File: tb/tb_c1908_secded.sv
// Self-checking bench for c1908_secded against a codeword-level SEC/DED reference model.
module tb_c1908_secded;

`ifdef C1908_SECDED_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        correct_en;
  logic [15:0] data_in;
  logic [5:0]  check_in;
  logic [15:0] data_out;
  logic [5:0]  syndrome_out;
  logic        single_err;
  logic        double_err;
  logic        out_valid;

  int n_checks;
  int n_fail;

  c1908_secded dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .correct_en   (correct_en),
    .data_in      (data_in),
    .check_in     (check_in),
    .data_out     (data_out),
    .syndrome_out (syndrome_out),
    .single_err   (single_err),
    .double_err   (double_err),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: syndrome = XOR of the positions of all set codeword bits.
  function automatic void model(input logic [15:0] d, input logic [5:0] c, input logic ce,
                                output logic [15:0] dout, output logic [5:0] syn,
                                output logic se, output logic de);
    int dp[22];
    int s, par, di, hi;
    s = 0; par = 0; di = 0; hi = 0;
    for (int p = 0; p < 22; p++) dp[p] = -1;
    for (int p = 1; p <= 21; p++) begin
      logic b;
      if ((p & (p - 1)) == 0) begin
        b = c[hi];
        hi++;
      end else begin
        b = d[di];
        dp[p] = di;
        di++;
      end
      if (b) begin
        s = s ^ p;
        par = par ^ 1;
      end
    end
    par = par ^ int'(c[5]);
    syn = {1'(par), 5'(s)};
    se = 1'b0;
    de = 1'b0;
    if (par == 0) de = (s != 0);
    else if (s > 21) de = 1'b1;
    else se = 1'b1;
    dout = d;
    if (se && ce && s > 0 && dp[s] >= 0) dout[dp[s]] = ~d[dp[s]];
  endfunction

  function automatic logic [5:0] encode(input logic [15:0] d);
    logic [15:0] dd;
    logic [5:0]  syn;
    logic        se, de;
    model(d, 6'h00, 1'b0, dd, syn, se, de);
    return {^{d, syn[4:0]}, syn[4:0]};
  endfunction

  task automatic apply_one(input logic ce, input logic [15:0] d, input logic [5:0] c);
    @(negedge clk);
    in_valid = 1'b1; correct_en = ce; data_in = d; check_in = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; correct_en = 1'b0; data_in = '0; check_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, single_err, double_err, syndrome_out, data_out} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset: got v=%b se=%b de=%b syn=%h data=%h, expected all zero",
               out_valid, single_err, double_err, syndrome_out, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        ce[9]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    logic [15:0] d[9]   = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0003,
                            16'h0000, 16'h0000, 16'h8000, 16'h0000};
    logic [5:0]  c[9]   = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h00, 6'h3E, 6'h01, 6'h00, 6'h16};
    logic [15:0] xd[9]  = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0003,
                            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [5:0]  xs[9]  = '{6'h00, 6'h23, 6'h23, 6'h20, 6'h06, 6'h3E, 6'h21, 6'h35, 6'h36};
    logic        xse[9] = '{0, 1, 1, 1, 0, 0, 1, 1, 0};
    logic        xde[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      apply_one(ce[i], d[i], c[i]);
      n_checks++;
      if ({out_valid, single_err, double_err, syndrome_out, data_out} !==
          {1'b1, xse[i], xde[i], xs[i], xd[i]}) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b se=%b de=%b syn=%h data=%h, expected v=1 se=%b de=%b syn=%h data=%h",
                 i, out_valid, single_err, double_err, syndrome_out, data_out,
                 xse[i], xde[i], xs[i], xd[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      logic [15:0] d, e_dat;
      logic [5:0]  c, e_syn;
      logic [21:0] cw;
      logic        ce, e_se, e_de;
      int          nerr, p1, p2;
      d = 16'($urandom);
      ce = 1'($urandom_range(0, 1));
      cw = {encode(d), d};
      nerr = $urandom_range(0, 3);
      p1 = $urandom_range(0, 21);
      p2 = (p1 + 1 + $urandom_range(0, 20)) % 22;
      if (nerr >= 1) cw[p1] = ~cw[p1];
      if (nerr == 2) cw[p2] = ~cw[p2];
      if (nerr == 3) cw[21:16] = 6'($urandom);
      c = cw[21:16];
      apply_one(ce, cw[15:0], c);
      model(cw[15:0], c, ce, e_dat, e_syn, e_se, e_de);
      n_checks++;
      if ({out_valid, single_err, double_err, syndrome_out, data_out} !==
          {1'b1, e_se, e_de, e_syn, e_dat}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b se=%b de=%b syn=%h data=%h, expected v=1 se=%b de=%b syn=%h data=%h",
                 it, out_valid, single_err, double_err, syndrome_out, data_out,
                 e_se, e_de, e_syn, e_dat);
      end
      if (nerr == 1 && ce) begin
        n_checks++;
        if ({single_err, double_err, data_out} !== {1'b1, 1'b0, d}) begin
          n_fail++;
          $display("FAIL recover[%0d]: got se=%b de=%b data=%h, expected se=1 de=0 data=%h",
                   it, single_err, double_err, data_out, d);
        end
      end
      if (nerr == 2) begin
        n_checks++;
        if ({single_err, double_err} !== 2'b01) begin
          n_fail++;
          $display("FAIL double[%0d]: got se=%b de=%b, expected se=0 de=1", it, single_err, double_err);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] e_dat;
    logic [5:0]  e_syn, c;
    logic        e_se, e_de;
    c = 6'h01;
    apply_one(1'b1, 16'h0010, c);
    model(16'h0010, c, 1'b1, e_dat, e_syn, e_se, e_de);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = 16'($urandom); check_in = 6'($urandom); correct_en = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, single_err, double_err, syndrome_out, data_out} !==
          {1'b0, e_se, e_de, e_syn, e_dat}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b se=%b de=%b syn=%h data=%h, expected v=0 se=%b de=%b syn=%h data=%h",
                 i, out_valid, single_err, double_err, syndrome_out, data_out,
                 e_se, e_de, e_syn, e_dat);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    logic        vv[N];
    logic        cc[N];
    logic [15:0] dd[N];
    logic [5:0]  kk[N];
    logic [15:0] l_dat, t_dat;
    logic [5:0]  l_syn, t_syn;
    logic        l_se, l_de, t_se, t_de;
    l_dat = '0; l_syn = '0; l_se = 1'b0; l_de = 1'b0;
    for (int i = 0; i < N; i++) begin
      vv[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cc[i] = 1'($urandom);
      dd[i] = 16'($urandom);
      kk[i] = ($urandom_range(0, 1) == 1) ? encode(dd[i]) ^ 6'(1 << $urandom_range(0, 5))
                                           : 6'($urandom);
    end
    for (int t = 0; t < N + LAT - 1; t++) begin
      int idx;
      @(negedge clk);
      if (t < N) begin
        in_valid = vv[t]; correct_en = cc[t]; data_in = dd[t]; check_in = kk[t];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      idx = t - (LAT - 1);
      if (idx >= 0 && idx < N) begin
        if (vv[idx]) begin
          model(dd[idx], kk[idx], cc[idx], t_dat, t_syn, t_se, t_de);
          l_dat = t_dat; l_syn = t_syn; l_se = t_se; l_de = t_de;
        end
        n_checks++;
        if ({out_valid, single_err, double_err, syndrome_out, data_out} !==
            {vv[idx], l_se, l_de, l_syn, l_dat}) begin
          n_fail++;
          $display("FAIL stream[%0d]: got v=%b se=%b de=%b syn=%h data=%h, expected v=%b se=%b de=%b syn=%h data=%h",
                   idx, out_valid, single_err, double_err, syndrome_out, data_out,
                   vv[idx], l_se, l_de, l_syn, l_dat);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [15:0] w, e_dat;
    logic [5:0]  wc, e_syn;
    logic        e_se, e_de;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; correct_en = 1'b1; data_in = 16'($urandom); check_in = 6'($urandom);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, single_err, double_err, syndrome_out, data_out} !== 25'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b se=%b de=%b syn=%h data=%h, expected all zero",
               out_valid, single_err, double_err, syndrome_out, data_out);
    end
    repeat (2) begin
      @(negedge clk);
      data_in = 16'($urandom); check_in = 6'($urandom);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, single_err, double_err, syndrome_out, data_out} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_held: got v=%b se=%b de=%b syn=%h data=%h, expected all zero",
               out_valid, single_err, double_err, syndrome_out, data_out);
    end
    w = 16'h0400;
    wc = 6'h00;
    model(w, wc, 1'b1, e_dat, e_syn, e_se, e_de);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; correct_en = 1'b1; data_in = w; check_in = wc;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b, expected v=0", out_valid);
    end
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (k < LAT) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL post_reset_edge%0d: got v=%b, expected v=0", k, out_valid);
        end
      end else if ({out_valid, single_err, double_err, syndrome_out, data_out} !==
                   {1'b1, e_se, e_de, e_syn, e_dat}) begin
        n_fail++;
        $display("FAIL post_reset_word: got v=%b se=%b de=%b syn=%h data=%h, expected v=1 se=%b de=%b syn=%h data=%h",
                 out_valid, single_err, double_err, syndrome_out, data_out,
                 e_se, e_de, e_syn, e_dat);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
